lcd_dma_sched: RTL and testbench
================================

LCD_DMA_SCHED -- requirements
Module: lcd_dma_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning words per AHB burst.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning words per panel FIFO.
REQ-003 HCLK  in  1  system clock; all logic on rising edge; single clock domain.
REQ-004 HRESET  in  1  synchronous, active-high reset.
REQ-005 lcd_en  in  1  controller enable (LCD_CTRL.LCDEN).
REQ-006 dual_panel  in  1  1 = upper and lower panels both fetched.
REQ-007 upbase  in  32  upper-panel frame base (LCD_UPBASE), word aligned.
REQ-008 lpbase  in  32  lower-panel frame base (LCD_LPBASE), word aligned.
REQ-009 frame_words  in  20  words per panel per frame; bits [1:0] ignored.
REQ-010 fp_pulse  in  1  one-cycle frame-start strobe.
REQ-011 up_free  in  5  free words in upper FIFO.
REQ-012 lp_free  in  5  free words in lower FIFO.
REQ-013 burst_req  out  1  burst request to AHB master.
REQ-014 burst_addr  out  32  start byte address of the requested burst.
REQ-015 burst_panel  out  1  0 = upper, 1 = lower; selects FIFO push target.
REQ-016 burst_ack  in  1  master has accepted the request.
REQ-017 burst_done  in  1  one-cycle strobe when the last beat is pushed.
REQ-018 upcurr  out  32  next upper fetch address (LCD_UPCURR).
REQ-019 lpcurr  out  32  next lower fetch address (LCD_LPCURR).
REQ-020 frame_done  out  1  one-cycle pulse when all panels are fetched (LNBU source).

Function
REQ-021 FSM states SHALL be IDLE, WAIT_FP, ARB, REQ, XFER, DONE.
REQ-022 IDLE -> WAIT_FP when lcd_en=1; any state except XFER -> IDLE on the next edge when lcd_en=0.
REQ-023 On fp_pulse in WAIT_FP or DONE: upcurr<=upbase, lpcurr<=lpbase, up_rem<=frame_words&~3, lp_rem<=dual_panel ? frame_words&~3 : 0; go to ARB.
REQ-024 Panel eligibility in ARB: rem>0 and free>=BURST_LEN.
REQ-025 Both panels eligible: round-robin; the panel not served last wins; last_served resets to lower, so upper wins first.
REQ-026 One panel eligible: grant it. None eligible with rem left: stay in ARB. Both rem=0: go to DONE and pulse frame_done for exactly one cycle.
REQ-027 ARB grant -> REQ on the next edge; burst_req=1 in the first REQ cycle.
REQ-028 burst_addr and burst_panel SHALL stay stable while burst_req=1.
REQ-029 burst_req=1 and burst_ack=1 in the same cycle -> XFER; burst_req=0 on the next cycle.
REQ-030 In XFER on burst_done: curr += 4*BURST_LEN (mod 2^32, wrap permitted) and rem -= BURST_LEN for the served panel; last_served updated; back to ARB.
REQ-031 fp_pulse in ARB/REQ/XFER SHALL be latched as fp_pend. The current burst completes; the next ARB performs the REQ-023 reload instead of arbitrating.
REQ-032 lcd_en=0 in REQ SHALL withdraw the request: burst_req=0 the next cycle, with no ack required.
REQ-033 lcd_en=0 in XFER SHALL finish the burst (wait for burst_done), then go to IDLE.
REQ-034 frame_words<BURST_LEN after masking SHALL give rem=0; the FSM goes straight to DONE with frame_done pulsed.
REQ-035 burst_ack or burst_done outside the expected state SHALL be ignored.

Reset
REQ-036 On HRESET: state=IDLE, burst_req=0, burst_addr=0, burst_panel=0, upcurr=0, lpcurr=0, frame_done=0, fp_pend=0, rem counters=0, last_served=1.
REQ-037 HRESET mid-burst SHALL abort immediately; no further completion is owed.

Structure
REQ-038 Package lcd_dma_pkg SHALL hold the state enum, the BURST_LEN/FIFO_DEPTH defaults and the panel-select constants.
REQ-039 One sub-module lcd_dma_rr_arb SHALL implement the 2-way round-robin with last_served state; the rest SHALL stay in lcd_dma_sched.

Verification
REQ-040 Single panel: upbase=0x1000, frame_words=16, frees=16, ack/done prompt -> 4 bursts at 0x1000, 0x1010, 0x1020, 0x1030 (panel 0); frame_done once; upcurr=0x1040.
REQ-041 Dual panel: upbase=0x1000, lpbase=0x8000, frame_words=8, both free=16 -> grants alternate U,L,U,L; addresses 0x1000, 0x8000, 0x1010, 0x8010.
REQ-042 Backpressure: up_free=3 for 20 cycles -> burst_req stays 0 and the state stays ARB; up_free=4 -> req on the second cycle.
REQ-043 fp_pulse during XFER -> the burst completes, then upcurr reloads to upbase; no extra frame_done.
REQ-044 lcd_en drops in REQ before ack -> burst_req=0 next cycle, IDLE; drops in XFER -> waits for burst_done, then IDLE.
REQ-045 Wrap: upbase=0xFFFFFFF0, frame_words=8 -> second burst at 0x00000000.

Source files
------------

// File: rtl/lcd_dma_pkg.sv
// Shared types and constants for the LCD DMA burst scheduler.
// Holds the scheduler state encoding, parameter defaults and panel select values.
package lcd_dma_pkg;

    localparam int unsigned BURST_LEN_DEF  = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    localparam logic PANEL_UP = 1'b0;
    localparam logic PANEL_LP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_FP = 3'd1,
        ST_ARB     = 3'd2,
        ST_REQ     = 3'd3,
        ST_XFER    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Remaining-word count after one burst, floored at zero.
    function automatic logic [19:0] rem_after_burst(input logic [19:0] rem,
                                                    input logic [19:0] burst);
        return (rem > burst) ? (rem - burst) : 20'd0;
    endfunction

endpackage

// File: rtl/lcd_dma_rr_arb.sv
// Two-way round-robin arbiter between the upper and lower panel FIFOs.
// last_served resets to the lower panel so the upper panel wins the first tie.
module lcd_dma_rr_arb
    import lcd_dma_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic up_elig,
    input  logic lp_elig,
    input  logic served_valid,
    input  logic served_panel,
    output logic grant_valid,
    output logic grant_panel
);

    logic last_served;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= PANEL_LP;
        end else if (served_valid) begin
            last_served <= served_panel;
        end
    end

    always_comb begin
        grant_valid = up_elig | lp_elig;
        if (up_elig && lp_elig) begin
            grant_panel = ~last_served;
        end else if (lp_elig) begin
            grant_panel = PANEL_LP;
        end else begin
            grant_panel = PANEL_UP;
        end
    end

endmodule

// File: rtl/lcd_dma_sched.sv
// Frame fetch scheduler: walks the upper/lower panel frame buffers in
// BURST_LEN-word bursts, issuing requests to the AHB master as FIFO room allows.
module lcd_dma_sched
    import lcd_dma_pkg::*;
#(
    parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        lcd_en,
    input  logic        dual_panel,
    input  logic [31:0] upbase,
    input  logic [31:0] lpbase,
    input  logic [19:0] frame_words,
    input  logic        fp_pulse,
    input  logic [4:0]  up_free,
    input  logic [4:0]  lp_free,
    output logic        burst_req,
    output logic [31:0] burst_addr,
    output logic        burst_panel,
    input  logic        burst_ack,
    input  logic        burst_done,
    output logic [31:0] upcurr,
    output logic [31:0] lpcurr,
    output logic        frame_done,
    output state_t      dbg_state
);

    localparam logic [19:0] BL20   = 20'(BURST_LEN);
    localparam logic [5:0]  BL6    = 6'(BURST_LEN);
    localparam logic [5:0]  DEPTH6 = 6'(FIFO_DEPTH);
    localparam logic [31:0] STEP   = 32'(4 * BURST_LEN);

    state_t      state, next_state;
    logic [19:0] up_rem, lp_rem;
    logic        fp_pend;

    logic [19:0] fw_masked, load_rem;
    logic [5:0]  up_room, lp_room;
    logic        up_elig, lp_elig, grant_valid, grant_panel;
    logic        all_done, reload, arb_grant, to_done, xfer_done;

    assign fw_masked = frame_words & ~20'h3;
    assign load_rem  = (fw_masked < BL20) ? 20'd0 : fw_masked;

    // A FIFO can never really hold more than its depth; clamp a bogus report.
    assign up_room = ({1'b0, up_free} > DEPTH6) ? DEPTH6 : {1'b0, up_free};
    assign lp_room = ({1'b0, lp_free} > DEPTH6) ? DEPTH6 : {1'b0, lp_free};
    assign up_elig = (up_rem != 20'd0) && (up_room >= BL6);
    assign lp_elig = (lp_rem != 20'd0) && (lp_room >= BL6);
    assign all_done = (up_rem == 20'd0) && (lp_rem == 20'd0);

    assign reload    = lcd_en && ((((state == ST_WAIT_FP) || (state == ST_DONE)) && fp_pulse)
                                  || ((state == ST_ARB) && fp_pend));
    assign to_done   = (state == ST_ARB) && lcd_en && !fp_pend && all_done;
    assign arb_grant = (state == ST_ARB) && lcd_en && !fp_pend && !all_done && grant_valid;
    assign xfer_done = (state == ST_XFER) && burst_done;

    lcd_dma_rr_arb u_arb (
        .clk          (HCLK),
        .rst          (HRESET),
        .up_elig      (up_elig),
        .lp_elig      (lp_elig),
        .served_valid (xfer_done),
        .served_panel (burst_panel),
        .grant_valid  (grant_valid),
        .grant_panel  (grant_panel)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (lcd_en) next_state = ST_WAIT_FP;
            ST_WAIT_FP: if (!lcd_en) next_state = ST_IDLE;
                        else if (fp_pulse) next_state = ST_ARB;
            ST_ARB:     if (!lcd_en) next_state = ST_IDLE;
                        else if (fp_pend) next_state = ST_ARB;
                        else if (all_done) next_state = ST_DONE;
                        else if (grant_valid) next_state = ST_REQ;
            ST_REQ:     if (!lcd_en) next_state = ST_IDLE;
                        else if (burst_ack) next_state = ST_XFER;
            ST_XFER:    if (burst_done) next_state = lcd_en ? ST_ARB : ST_IDLE;
            ST_DONE:    if (!lcd_en) next_state = ST_IDLE;
                        else if (fp_pulse) next_state = ST_ARB;
            default:    next_state = ST_IDLE;
        endcase
    end

    // burst_req is the valid: held with stable burst_addr/burst_panel until
    // burst_ack (ready) is seen in the same cycle, or withdrawn when lcd_en drops.
    always_comb begin
        burst_req = (state == ST_REQ);
        dbg_state = state;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            burst_addr  <= 32'd0;
            burst_panel <= PANEL_UP;
            upcurr      <= 32'd0;
            lpcurr      <= 32'd0;
            up_rem      <= 20'd0;
            lp_rem      <= 20'd0;
            frame_done  <= 1'b0;
            fp_pend     <= 1'b0;
        end else begin
            frame_done <= to_done;
            if (reload) begin
                upcurr <= upbase;
                lpcurr <= lpbase;
                up_rem <= load_rem;
                lp_rem <= dual_panel ? load_rem : 20'd0;
            end else if (xfer_done) begin
                if (burst_panel == PANEL_LP) begin
                    lpcurr <= lpcurr + STEP;
                    lp_rem <= rem_after_burst(lp_rem, BL20);
                end else begin
                    upcurr <= upcurr + STEP;
                    up_rem <= rem_after_burst(up_rem, BL20);
                end
            end
            if (arb_grant) begin
                burst_panel <= grant_panel;
                burst_addr  <= (grant_panel == PANEL_LP) ? lpcurr : upcurr;
            end
            // A frame strobe mid-burst is remembered and honoured at the next ARB.
            if (reload || state == ST_IDLE) begin
                fp_pend <= 1'b0;
            end else if (fp_pulse && (state == ST_ARB || state == ST_REQ || state == ST_XFER)) begin
                fp_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_dma_sched.sv
// Directed bench for lcd_dma_sched: a frame-level fetch model predicts every
// accepted burst, and a single negedge process checks the DUT against it.
module tb_lcd_dma_sched;
    import lcd_dma_pkg::*;

    localparam int BL = 4;

    logic        clk, HRESET, lcd_en, dual_panel, fp_pulse;
    logic [31:0] upbase, lpbase;
    logic [19:0] frame_words;
    logic [4:0]  up_free, lp_free;
    logic        burst_req, burst_panel, burst_ack, burst_done, frame_done;
    logic [31:0] burst_addr, upcurr, lpcurr;
    state_t      dbg_state;

    lcd_dma_sched #(.BURST_LEN(BL), .FIFO_DEPTH(16)) dut (
        .HCLK(clk), .HRESET(HRESET), .lcd_en(lcd_en), .dual_panel(dual_panel),
        .upbase(upbase), .lpbase(lpbase), .frame_words(frame_words), .fp_pulse(fp_pulse),
        .up_free(up_free), .lp_free(lp_free), .burst_req(burst_req), .burst_addr(burst_addr),
        .burst_panel(burst_panel), .burst_ack(burst_ack), .burst_done(burst_done),
        .upcurr(upcurr), .lpcurr(lpcurr), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int tests_run = 0;
    int tests_failed = 0;
    logic [32:0] exp_q[$];   // {panel, start address} of each burst the model expects
    logic m_last = PANEL_LP; // model's memory of the panel served last
    int fd_cnt = 0;
    bit resp_en = 1'b0;
    bit stray_en = 1'b0;
    int done_dly = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Frame-level model: round-robin over panels with words left, assuming ample FIFO room.
    task automatic plan_frame(input logic [31:0] ub, input logic [31:0] lb,
                              input logic [19:0] fw, input logic dual);
        int urem, lrem;
        logic [31:0] ua, la;
        logic pick;
        urem = int'(fw) / 4 * 4;
        if (urem < BL) urem = 0;
        lrem = dual ? urem : 0;
        ua = ub;
        la = lb;
        while (urem > 0 || lrem > 0) begin
            if (urem > 0 && lrem > 0) pick = ~m_last;
            else pick = (lrem > 0) ? PANEL_LP : PANEL_UP;
            if (pick == PANEL_LP) begin
                exp_q.push_back({PANEL_LP, la});
                la = la + 32'(4 * BL);
                lrem = (lrem > BL) ? lrem - BL : 0;
            end else begin
                exp_q.push_back({PANEL_UP, ua});
                ua = ua + 32'(4 * BL);
                urem = (urem > BL) ? urem - BL : 0;
            end
            m_last = pick;
        end
    endtask

    // driver tasks
    task automatic do_reset();
        HRESET = 1'b1;
        repeat (3) @(negedge clk);
        HRESET = 1'b0;
        m_last = PANEL_LP;
    endtask

    task automatic pulse_fp();
        fp_pulse = 1'b1;
        @(negedge clk);
        fp_pulse = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int budget, input string name);
        int n = 0;
        while (dbg_state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(dbg_state), 32'(s));
    endtask

    // Responder plus scoreboard: acks and completes bursts, checks each accepted one.
    initial begin
        logic [32:0] e;
        logic prev_req = 1'b0;
        logic [32:0] prev_cmd = '0;
        int phase = 0;
        int cnt = 0;
        burst_ack = 1'b0;
        burst_done = 1'b0;
        forever begin
            @(negedge clk);
            burst_ack = 1'b0;
            burst_done = 1'b0;
            if (frame_done) fd_cnt++;
            if (burst_req && prev_req)
                check("req_stable", {31'd0, burst_panel} ^ burst_addr, {31'd0, prev_cmd[32]} ^ prev_cmd[31:0]);
            prev_req = burst_req;
            prev_cmd = {burst_panel, burst_addr};
            if (phase == 0) begin
                if (stray_en) begin
                    burst_ack = 1'b1;
                    burst_done = 1'b1;
                end else if (resp_en && burst_req) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_burst: got addr 0x%08h, expected none", burst_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("burst_addr", burst_addr, e[31:0]);
                        check("burst_panel", {31'd0, burst_panel}, {31'd0, e[32]});
                    end
                    burst_ack = 1'b1;
                    phase = 1;
                    cnt = done_dly;
                end
            end else if (cnt > 0) begin
                cnt--;
            end else begin
                burst_done = 1'b1;
                phase = 0;
            end
        end
    end

    initial begin
        int fd_base, n;
        HRESET = 1'b1; lcd_en = 1'b0; dual_panel = 1'b0; fp_pulse = 1'b0;
        upbase = 32'h0; lpbase = 32'h0; frame_words = 20'd0;
        up_free = 5'd16; lp_free = 5'd16;
        do_reset();
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_req", {31'd0, burst_req}, 32'd0);
        check("rst_addr", burst_addr, 32'd0);
        check("rst_panel", {31'd0, burst_panel}, 32'd0);
        check("rst_upcurr", upcurr, 32'd0);
        check("rst_lpcurr", lpcurr, 32'd0);
        check("rst_fd", {31'd0, frame_done}, 32'd0);

        // single panel, four bursts
        resp_en = 1'b1;
        upbase = 32'h1000; frame_words = 20'd16;
        lcd_en = 1'b1;
        wait_state(ST_WAIT_FP, 5, "t1_wait_fp");
        plan_frame(upbase, lpbase, frame_words, 1'b0);
        check("model_t1_b3", exp_q[3][31:0], 32'h1030);
        fd_base = fd_cnt;
        pulse_fp();
        wait_state(ST_DONE, 200, "t1_done");
        repeat (3) @(negedge clk);
        check("t1_fd_once", fd_cnt - fd_base, 1);
        check("t1_upcurr", upcurr, 32'h1040);
        check("t1_q_empty", exp_q.size(), 0);

        // dual panel alternation from a fresh reset
        do_reset();
        dual_panel = 1'b1; lpbase = 32'h8000; frame_words = 20'd8;
        wait_state(ST_WAIT_FP, 5, "t2_wait_fp");
        plan_frame(upbase, lpbase, frame_words, 1'b1);
        check("model_t2_b1", exp_q[1][31:0], 32'h8000);
        check("model_t2_b2", exp_q[2][31:0], 32'h1010);
        fd_base = fd_cnt;
        pulse_fp();
        wait_state(ST_DONE, 200, "t2_done");
        repeat (3) @(negedge clk);
        check("t2_fd_once", fd_cnt - fd_base, 1);
        check("t2_upcurr", upcurr, 32'h1020);
        check("t2_lpcurr", lpcurr, 32'h8020);
        check("t2_q_empty", exp_q.size(), 0);

        // backpressure on the upper FIFO
        dual_panel = 1'b0; upbase = 32'h2000; frame_words = 20'd4; up_free = 5'd3;
        plan_frame(upbase, lpbase, frame_words, 1'b0);
        pulse_fp();
        for (int i = 0; i < 20; i++) begin
            check("t3_bp_state", 32'(dbg_state), 32'(ST_ARB));
            check("t3_bp_req", {31'd0, burst_req}, 32'd0);
            @(negedge clk);
        end
        up_free = 5'd4;
        @(negedge clk);
        check("t3_req_2nd", {31'd0, burst_req}, 32'd1);
        wait_state(ST_DONE, 50, "t3_done");
        up_free = 5'd16;
        check("t3_upcurr", upcurr, 32'h2010);

        // frame strobe during a transfer
        upbase = 32'h3000; frame_words = 20'd8;
        exp_q.push_back({PANEL_UP, 32'h3000});
        m_last = PANEL_UP;
        plan_frame(upbase, lpbase, frame_words, 1'b0);
        repeat (2) @(negedge clk);
        fd_base = fd_cnt;
        pulse_fp();
        wait_state(ST_XFER, 20, "t4_xfer");
        pulse_fp();
        wait_state(ST_DONE, 200, "t4_done");
        repeat (3) @(negedge clk);
        check("t4_fd_once", fd_cnt - fd_base, 1);
        check("t4_upcurr", upcurr, 32'h3020);
        check("t4_q_empty", exp_q.size(), 0);

        // enable dropped while requesting
        resp_en = 1'b0;
        upbase = 32'h4000; frame_words = 20'd4;
        pulse_fp();
        n = 0;
        while (!burst_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_req_seen", {31'd0, burst_req}, 32'd1);
        check("t5_req_addr", burst_addr, 32'h4000);
        repeat (2) @(negedge clk);
        lcd_en = 1'b0;
        @(negedge clk);
        check("t5_withdraw", {31'd0, burst_req}, 32'd0);
        check("t5_idle", 32'(dbg_state), 32'(ST_IDLE));

        // enable dropped mid-transfer
        resp_en = 1'b1; done_dly = 5;
        plan_frame(upbase, lpbase, frame_words, 1'b0);
        lcd_en = 1'b1;
        wait_state(ST_WAIT_FP, 5, "t5b_wait_fp");
        fd_base = fd_cnt;
        pulse_fp();
        wait_state(ST_XFER, 20, "t5b_xfer");
        lcd_en = 1'b0;
        @(negedge clk);
        check("t5b_hold_xfer", 32'(dbg_state), 32'(ST_XFER));
        wait_state(ST_IDLE, 20, "t5b_idle");
        check("t5b_upcurr", upcurr, 32'h4010);
        check("t5b_no_fd", fd_cnt - fd_base, 0);
        done_dly = 1;

        // address wrap
        upbase = 32'hFFFF_FFF0; frame_words = 20'd8;
        lcd_en = 1'b1;
        wait_state(ST_WAIT_FP, 5, "t6_wait_fp");
        plan_frame(upbase, lpbase, frame_words, 1'b0);
        check("model_wrap", exp_q[1][31:0], 32'h0000_0000);
        pulse_fp();
        wait_state(ST_DONE, 100, "t6_done");
        check("t6_upcurr", upcurr, 32'h0000_0010);
        check("t6_q_empty", exp_q.size(), 0);

        // stray handshakes ignored, then a too-short frame
        stray_en = 1'b1;
        repeat (3) @(negedge clk);
        stray_en = 1'b0;
        check("t7_stray_state", 32'(dbg_state), 32'(ST_DONE));
        check("t7_stray_req", {31'd0, burst_req}, 32'd0);
        frame_words = 20'd3;
        fd_base = fd_cnt;
        pulse_fp();
        wait_state(ST_DONE, 10, "t7_done");
        repeat (3) @(negedge clk);
        check("t7_fd_once", fd_cnt - fd_base, 1);
        check("t7_upcurr", upcurr, 32'hFFFF_FFF0);
        check("final_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
